// File: rtl/parallel_pkg.sv
// Shared definitions for the parallel link master: command bytes, FSM states
// and the rising-edge count type.
package parallel_pkg;

   localparam logic [7:0] CMD_X_DEFAULT = 8'h78;
   localparam logic [7:0] CMD_Y_DEFAULT = 8'h79;
   localparam logic [7:0] CMD_Z_DEFAULT = 8'h7A;

   // Axis code 3 has no command byte and is rejected with an err pulse.
   localparam logic [1:0] AXIS_INVALID = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_HIGH,
      ST_LOW,
      ST_DONE
   } state_e;

   // Which link-clock rising edge the current HIGH/LOW pair belongs to (1..3).
   typedef logic [1:0] edge_t;

endpackage : parallel_pkg

// File: rtl/parallel_phase_timer.sv
// Half-period timer: counts 0..HALF-1 and flags the last cycle of a phase.
// A restart forces the count back to 0 so every new phase gets a full HALF.
module parallel_phase_timer #(
   parameter int unsigned HALF = 25
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart_i,
   output logic phase_end_o
);

   localparam logic [7:0] LAST = 8'(HALF - 1);

   logic [7:0] cnt_q;
   logic [7:0] cnt_d;

   // Next count: wrap at the end of a phase or on an explicit restart.
   always_comb begin
      phase_end_o = (cnt_q == LAST);
      cnt_d       = (restart_i || phase_end_o) ? 8'd0 : cnt_q + 8'd1;
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= 8'd0;
      end else begin
         // NOTE: state registers use non-blocking assignment so every flop
         // samples the pre-edge value of every other flop.
         cnt_q <= cnt_d;
      end
   end

endmodule : parallel_phase_timer

// File: rtl/parallel_master.sv
// Initiator end of the 8-bit parallel link. Sends one command byte with one
// link-clock pulse, turns the bus around, then clocks in a low and a high
// response byte on the next two pulses. All link outputs are registered.
module parallel_master
   import parallel_pkg::*;
#(
   parameter int unsigned HALF  = 25,
   parameter logic [7:0]  CMD_X = CMD_X_DEFAULT,
   parameter logic [7:0]  CMD_Y = CMD_Y_DEFAULT,
   parameter logic [7:0]  CMD_Z = CMD_Z_DEFAULT
) (
   input  logic        CLK_50,
   input  logic        iRSTN,
   input  logic        start,
   input  logic [1:0]  axis,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [15:0] result,
   output logic        RP_clock,
   output logic        RP_CS,
   inout  wire  [7:0]  RP_data
);

   state_e      state_q, state_d;
   edge_t       edge_q, edge_d;
   logic [7:0]  cmd_q, cmd_d;
   logic [7:0]  lo_q, lo_d;
   logic [15:0] result_q, result_d;
   logic        clk_q, clk_d;
   logic        cs_q, cs_d;
   logic        drive_q, drive_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic        phase_end;
   logic        restart;
   logic        link_phase_d;

   parallel_phase_timer #(.HALF(HALF)) u_timer (
      .clk        (CLK_50),
      .rst_n      (iRSTN),
      .restart_i  (restart),
      .phase_end_o(phase_end)
   );

   // Next-state logic and next values of every registered output.
   always_comb begin
      // NOTE: every variable gets a default before the case so no path
      // leaves one unassigned, which would otherwise infer a latch.
      state_d  = state_q;
      edge_d   = edge_q;
      cmd_d    = cmd_q;
      lo_d     = lo_q;
      result_d = result_q;
      err_d    = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (axis == AXIS_INVALID) begin
                  err_d = 1'b1;
               end else begin
                  unique case (axis)
                     2'd0:    cmd_d = CMD_X;
                     2'd1:    cmd_d = CMD_Y;
                     default: cmd_d = CMD_Z;
                  endcase
                  state_d = ST_SETUP;
               end
            end
         end
         ST_SETUP: begin
            if (phase_end) begin
               state_d = ST_HIGH;
               edge_d  = 2'd1;
            end
         end
         ST_HIGH: begin
            if (phase_end) state_d = ST_LOW;
         end
         ST_LOW: begin
            if (phase_end) begin
               unique case (edge_q)
                  2'd1: begin
                     state_d = ST_HIGH;
                     edge_d  = 2'd2;
                  end
                  2'd2: begin
                     lo_d    = RP_data;
                     state_d = ST_HIGH;
                     edge_d  = 2'd3;
                  end
                  default: begin
                     // High byte goes straight into result so it is valid
                     // in the same cycle as the done pulse.
                     result_d = {RP_data, lo_q};
                     state_d  = ST_DONE;
                  end
               endcase
            end
         end
         ST_DONE: begin
            // start is deliberately not looked at here.
            state_d = ST_IDLE;
            edge_d  = 2'd0;
         end
         default: state_d = ST_IDLE;
      endcase

      // Outputs are derived from the next state so they change on the same
      // edge as the state itself. The master releases the bus on the very
      // edge RP_CS rises, so the two sides never drive together.
      link_phase_d = (state_d == ST_HIGH) || (state_d == ST_LOW);
      clk_d        = (state_d == ST_HIGH);
      cs_d         = link_phase_d && (edge_d != 2'd1);
      drive_d      = (state_d == ST_SETUP) || (link_phase_d && (edge_d == 2'd1));
      busy_d       = (state_d != ST_IDLE) && (state_d != ST_DONE);
      done_d       = (state_d == ST_DONE);
      restart      = (state_d != state_q);
   end

   // State and output registers; reset returns the link to its idle levels.
   always_ff @(posedge CLK_50 or negedge iRSTN) begin
      if (!iRSTN) begin
         state_q  <= ST_IDLE;
         edge_q   <= 2'd0;
         cmd_q    <= 8'd0;
         lo_q     <= 8'd0;
         result_q <= 16'h0000;
         clk_q    <= 1'b0;
         cs_q     <= 1'b0;
         drive_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         edge_q   <= edge_d;
         cmd_q    <= cmd_d;
         lo_q     <= lo_d;
         result_q <= result_d;
         clk_q    <= clk_d;
         cs_q     <= cs_d;
         drive_q  <= drive_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign RP_data  = drive_q ? cmd_q : 8'hzz;
   assign RP_clock = clk_q;
   assign RP_CS    = cs_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;
   assign result   = result_q;

endmodule : parallel_master

// File: tb/tb_parallel_master.sv
// Directed bench for parallel_master: HALF=4 main instance plus a HALF=2
// instance, each with a small responder model on its link.
`timescale 1ns/1ps
module tb_parallel_master;

   logic        CLK_50 = 1'b0;
   logic        iRSTN;
   logic        start, start2;
   logic [1:0]  axis, axis2;
   wire         busy, done, err, busy2, done2, err2;
   wire  [15:0] result, result2;
   wire         RP_clock, RP_CS, RP_clock2, RP_CS2;
   wire  [7:0]  RP_data, RP_data2;

   int checks = 0;
   int failures = 0;
   int violations = 0;

   always #5 CLK_50 = ~CLK_50;

   parallel_master #(.HALF(4)) dut (
      .CLK_50(CLK_50), .iRSTN(iRSTN), .start(start), .axis(axis),
      .busy(busy), .done(done), .err(err), .result(result),
      .RP_clock(RP_clock), .RP_CS(RP_CS), .RP_data(RP_data)
   );

   parallel_master #(.HALF(2)) dut2 (
      .CLK_50(CLK_50), .iRSTN(iRSTN), .start(start2), .axis(axis2),
      .busy(busy2), .done(done2), .err(err2), .result(result2),
      .RP_clock(RP_clock2), .RP_CS(RP_CS2), .RP_data(RP_data2)
   );

   // Responder model for dut: first rising edge arrives with RP_CS=0,
   // low byte is offered until the third edge, then the high byte.
   logic [7:0] resp_lo = 8'h00;
   logic [7:0] resp_hi = 8'h00;
   int rise_cnt = 0;
   int rise_total = 0;
   always @(posedge RP_clock) begin
      rise_total <= rise_total + 1;
      rise_cnt   <= RP_CS ? rise_cnt + 1 : 1;
   end
   assign RP_data = RP_CS ? ((rise_cnt >= 3) ? resp_hi : resp_lo) : 8'hzz;

   // Responder model for dut2 with fixed bytes CD / AB.
   int rise_cnt2 = 0;
   int rise_total2 = 0;
   always @(posedge RP_clock2) begin
      rise_total2 <= rise_total2 + 1;
      rise_cnt2   <= RP_CS2 ? rise_cnt2 + 1 : 1;
   end
   assign RP_data2 = RP_CS2 ? ((rise_cnt2 >= 3) ? 8'hAB : 8'hCD) : 8'hzz;

   // Bus monitor: master drive on while responder owns the bus.
   always @(negedge CLK_50) begin
      if ((dut.drive_q && RP_CS) || (dut2.drive_q && RP_CS2)) violations <= violations + 1;
   end

   function automatic logic [7:0] cmd_of(input logic [1:0] ax);
      case (ax)
         2'd0:    return 8'h78;
         2'd1:    return 8'h79;
         default: return 8'h7A;
      endcase
   endfunction

   // One full transaction on dut with timing, data, edge and busy checks.
   task automatic run_txn(input logic [1:0] ax, input logic [7:0] lo, input logic [7:0] hi,
                          input int exp_cyc, input string tag);
      int cyc;
      int rbase;
      int cmd_bad;
      bit got;
      logic [15:0] exp_res;
      exp_res = {hi, lo};
      resp_lo = lo;
      resp_hi = hi;
      rbase   = rise_total;
      cmd_bad = 0;
      got     = 1'b0;
      @(negedge CLK_50);
      start = 1'b1;
      axis  = ax;
      @(posedge CLK_50);
      #1 start = 1'b0;
      cyc = 1;
      while (cyc <= 200 && !got) begin
         @(negedge CLK_50);
         if (cyc == 1) begin
            checks++;
            if (busy !== 1'b1) begin
               failures++;
               $display("FAIL %s busy_after_accept: got %b want 1", tag, busy);
            end
         end
         if (!RP_CS && dut.drive_q && RP_data !== cmd_of(ax)) cmd_bad++;
         if (done) got = 1'b1;
         else begin
            @(posedge CLK_50);
            cyc++;
         end
      end
      checks++;
      if (!got || cyc != exp_cyc) begin
         failures++;
         $display("FAIL %s done_cycle: got %0d (seen=%0b) want %0d", tag, cyc, got, exp_cyc);
      end
      checks++;
      if (result !== exp_res) begin
         failures++;
         $display("FAIL %s result: got %h want %h", tag, result, exp_res);
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL %s busy_in_done: got %b want 0", tag, busy);
      end
      checks++;
      if (rise_total - rbase != 3) begin
         failures++;
         $display("FAIL %s rp_clock_edges: got %0d want 3", tag, rise_total - rbase);
      end
      checks++;
      if (cmd_bad != 0) begin
         failures++;
         $display("FAIL %s cmd_byte: %0d cycles differ from %h", tag, cmd_bad, cmd_of(ax));
      end
      @(negedge CLK_50);
      checks++;
      if (done !== 1'b0) begin
         failures++;
         $display("FAIL %s done_one_cycle: got %b want 0", tag, done);
      end
   endtask

   task automatic test_reset();
      iRSTN  = 1'b0;
      start  = 1'b0;
      axis   = 2'd0;
      start2 = 1'b0;
      axis2  = 2'd0;
      #12;
      checks++;
      if ({busy, done, err, RP_clock, RP_CS, dut.drive_q} !== 6'b0 || result !== 16'h0000) begin
         failures++;
         $display("FAIL reset_values: got busy=%b done=%b err=%b clk=%b cs=%b drv=%b result=%h want all 0",
                  busy, done, err, RP_clock, RP_CS, dut.drive_q, result);
      end
      @(negedge CLK_50);
      iRSTN = 1'b1;
      @(negedge CLK_50);
   endtask

   task automatic test_main();
      run_txn(2'd1, 8'h34, 8'h12, 29, "main_axis1");
   endtask

   task automatic test_invalid_axis();
      bit toggled;
      toggled = 1'b0;
      @(negedge CLK_50);
      start = 1'b1;
      axis  = 2'd3;
      @(posedge CLK_50);
      #1 start = 1'b0;
      @(negedge CLK_50);
      checks++;
      if (err !== 1'b1) begin
         failures++;
         $display("FAIL err_pulse: got %b want 1", err);
      end
      @(negedge CLK_50);
      checks++;
      if (err !== 1'b0) begin
         failures++;
         $display("FAIL err_one_cycle: got %b want 0", err);
      end
      for (int i = 0; i < 10; i++) begin
         if (busy || RP_clock || RP_CS) toggled = 1'b1;
         @(negedge CLK_50);
      end
      checks++;
      if (toggled) begin
         failures++;
         $display("FAIL err_link_quiet: got activity=1 want 0");
      end
   endtask

   task automatic test_back_to_back();
      int dcount;
      int dcyc[2];
      logic [7:0] cmds[2];
      int ncmd;
      bit prev_busy;
      dcount    = 0;
      ncmd      = 0;
      prev_busy = 1'b0;
      dcyc[0] = -1; dcyc[1] = -1;
      cmds[0] = 8'h00; cmds[1] = 8'h00;
      resp_lo = 8'h22;
      resp_hi = 8'h11;
      @(negedge CLK_50);
      start = 1'b1;
      axis  = 2'd0;
      for (int c = 0; c < 80; c++) begin
         if (c > 0) begin
            if (done) begin
               if (dcount < 2) dcyc[dcount] = c;
               dcount++;
            end
            if (busy && !prev_busy) begin
               if (ncmd < 2) cmds[ncmd] = RP_data;
               ncmd++;
            end
            prev_busy = busy;
         end
         if (c == 1) axis = 2'd2;
         if (c == 40) start = 1'b0;
         @(posedge CLK_50);
         @(negedge CLK_50);
      end
      checks++;
      if (dcount != 2 || dcyc[0] != 29 || dcyc[1] != 59) begin
         failures++;
         $display("FAIL b2b_done: got count=%0d at %0d,%0d want 2 at 29,59", dcount, dcyc[0], dcyc[1]);
      end
      checks++;
      if (ncmd != 2 || cmds[0] !== 8'h78 || cmds[1] !== 8'h7A) begin
         failures++;
         $display("FAIL b2b_cmds: got n=%0d %h,%h want 2 78,7a", ncmd, cmds[0], cmds[1]);
      end
      checks++;
      if (result !== 16'h1122) begin
         failures++;
         $display("FAIL b2b_result: got %h want 1122", result);
      end
   endtask

   task automatic test_reset_mid();
      resp_lo = 8'h34;
      resp_hi = 8'h12;
      @(negedge CLK_50);
      start = 1'b1;
      axis  = 2'd1;
      @(posedge CLK_50);
      #1 start = 1'b0;
      // Cycles 13..16 are the second HIGH phase for HALF=4.
      for (int c = 1; c < 14; c++) @(posedge CLK_50);
      @(negedge CLK_50);
      checks++;
      if (RP_clock !== 1'b1 || RP_CS !== 1'b1) begin
         failures++;
         $display("FAIL mid_reset_setup: got clk=%b cs=%b want 1,1", RP_clock, RP_CS);
      end
      iRSTN = 1'b0;
      #1;
      checks++;
      if ({RP_clock, RP_CS, dut.drive_q, busy} !== 4'b0 || result !== 16'h0000) begin
         failures++;
         $display("FAIL mid_reset_values: got clk=%b cs=%b drv=%b busy=%b result=%h want 0",
                  RP_clock, RP_CS, dut.drive_q, busy, result);
      end
      @(negedge CLK_50);
      iRSTN = 1'b1;
      @(negedge CLK_50);
      run_txn(2'd0, 8'h5A, 8'hC3, 29, "after_reset");
   endtask

   task automatic test_min_half();
      int cyc;
      int rbase;
      int cmd_bad;
      bit got;
      rbase   = rise_total2;
      cmd_bad = 0;
      got     = 1'b0;
      @(negedge CLK_50);
      start2 = 1'b1;
      axis2  = 2'd2;
      @(posedge CLK_50);
      #1 start2 = 1'b0;
      cyc = 1;
      while (cyc <= 100 && !got) begin
         @(negedge CLK_50);
         if (!RP_CS2 && dut2.drive_q && RP_data2 !== 8'h7A) cmd_bad++;
         if (done2) got = 1'b1;
         else begin
            @(posedge CLK_50);
            cyc++;
         end
      end
      checks++;
      if (!got || cyc != 15) begin
         failures++;
         $display("FAIL half2_done_cycle: got %0d (seen=%0b) want 15", cyc, got);
      end
      checks++;
      if (result2 !== 16'hABCD) begin
         failures++;
         $display("FAIL half2_result: got %h want abcd", result2);
      end
      checks++;
      if (rise_total2 - rbase != 3 || cmd_bad != 0) begin
         failures++;
         $display("FAIL half2_link: got edges=%0d cmd_errs=%0d want 3,0", rise_total2 - rbase, cmd_bad);
      end
   endtask

   task automatic test_turnaround();
      checks++;
      if (violations != 0) begin
         failures++;
         $display("FAIL turnaround: got %0d overlap cycles want 0", violations);
      end
   endtask

   initial begin
      test_reset();
      test_main();
      test_invalid_axis();
      test_back_to_back();
      test_reset_mid();
      test_min_half();
      test_turnaround();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_parallel_master
